shift_ctrl: RTL
===============

# shift_ctrl

Multi-cycle shift controller that shares one single-bit logical shifter datapath between two requesters. Each request carries a 32-bit operand, a shift amount and a direction. The block arbitrates round-robin, applies one 1-bit shift per clock until the amount is exhausted, and returns the result with a valid/ready handshake. It sits between address-generation clients and the shared shift unit, which shifts by one position per cycle: `LEFT_SHIFT` = 0, `RIGHT_SHIFT` = 1.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- AMT_W, 5, shift-amount width; amounts range from 0 to 2^AMT_W-1

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_data  input  WIDTH  requester 0 operand
- req0_amt  input  AMT_W  requester 0 shift amount
- req0_dir  input  1  requester 0 direction: 0 left, 1 right
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir: same meanings as the requester 0 ports, for requester 1
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_id  output  1  index of the requester that owns the result
- busy  output  1  high in SHIFT or DONE

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset state is IDLE.
- Round-robin pointer `rr` names the preferred requester. Reset value is 0.
- IDLE:
  - Grant the preferred requester if it is valid, otherwise the other one if valid.
  - reqN_ready = (state==IDLE) & granted N. It is combinational and at most one is high.
  - On the handshake, latch data, amt, dir and id into the working registers.
  - Next state is SHIFT if amt≠0, otherwise DONE. Data is passed through unshifted when amt=0.
- SHIFT, each cycle:
  - work = dir ? work>>1 : work<<1. The shift is logical and zero-filled.
  - cnt decrements by 1.
  - When cnt reaches 1, the current shift is the last one, and the next state is DONE.
- DONE:
  - out_valid=1. out_data=work and out_id=id are held stable.
  - On out_valid & out_ready: go to IDLE and set rr = ~id, so the other requester is preferred next.
- No new request is accepted while busy. A request may be accepted no earlier than the cycle after the out handshake.
- reqN_valid may drop without being accepted. Requests are never queued internally.
- Requester inputs are sampled only in the accept cycle. Later changes have no effect on the request in flight.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr=0.
  - out_valid=0, out_data=0, out_id=0, busy=0.
  - req0_ready=req1_ready=0 are forced while rst_n=0.
  - Deassertion of reset is synchronized externally. The first accept can happen on the first edge with rst_n=1.
- Latency: accept at edge t gives out_valid high after edge t+amt+1. For amt=0, out_valid is high after edge t+1.
- Throughput: one request per amt+2 cycles minimum, when out_ready is held high.
- Backpressure: out_valid, out_data and out_id are held indefinitely while out_ready=0.
- Simultaneous valids: the requester named by rr wins. The loser's ready stays 0 and it must keep valid asserted.
- Back-to-back from the same requester with the other idle: it is granted again, because the fallback path applies even though rr points away from it.
- Reset mid-SHIFT or mid-DONE:
  - The in-flight result is discarded and out_valid drops immediately.
  - No result is produced for that request after reset.
- Maximum amt=31 with WIDTH=32: the result keeps only the original bit 0 (left) or bit 31 (right).

## Test plan
- Left shift: req0 data=32'd7, amt=1, dir=0, out_ready=1.
  - Required: out_data=14 and out_id=0.
  - out_valid rises 2 edges after accept and stays high for 1 cycle.
- Right shift: req1 data=32'd7, amt=1, dir=1. Then req1 data=32'd3, amt=2, dir=1.
  - Required: results 3 then 0, both with out_id=1.
  - Latencies are 2 and 3 cycles respectively.
- Boundary amounts:
  - amt=0 with data=0xA5A5A5A5 → out_data=0xA5A5A5A5 after 1 cycle.
  - amt=31 left of 1 → 0x80000000 after 32 cycles.
  - amt=31 right of 0x80000000 → 1 after 32 cycles.
- Arbitration: req0 and req1 both held valid with different data, looping for 4 results.
  - Required grant order is 0, 1, 0, 1.
  - ready is never high on both requesters in the same cycle.
- Backpressure: out_ready=0 for 10 cycles during DONE.
  - out_valid, out_data and out_id stay constant.
  - Both reqN_ready stay 0 until out_ready=1, then the FSM returns to IDLE on the next edge.
- Reset mid-operation: pulse rst_n low during SHIFT of amt=20.
  - Required: out_valid, busy and out_data go to 0 asynchronously.
  - rr returns to 0, and the next simultaneous request pair grants req0 first.

Source files
------------

// File: rtl/shift_ctrl.sv
// Two-requester shift controller. A single 1-bit logical shifter is shared round-robin.
// Each accepted request is shifted one position per clock and returned on a valid/ready port.
module shift_ctrl #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_data,
   input  logic [AMT_W-1:0] req0_amt,
   input  logic             req0_dir,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_data,
   input  logic [AMT_W-1:0] req1_amt,
   input  logic             req1_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_id,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic             rr;
   logic [WIDTH-1:0] work;
   logic [AMT_W-1:0] cnt;
   logic             dir;
   logic             id;

   logic             gnt0, gnt1, accept;
   logic [WIDTH-1:0] sel_data;
   logic [AMT_W-1:0] sel_amt;
   logic             sel_dir;

   // Preferred requester wins; otherwise fall back to whichever one is valid.
   always_comb begin
      gnt0       = req0_valid & (~rr | ~req1_valid);
      gnt1       = req1_valid & ~gnt0;
      req0_ready = rst_n & (state == IDLE) & gnt0;
      req1_ready = rst_n & (state == IDLE) & gnt1;
      accept     = req0_ready | req1_ready;
      sel_data   = gnt1 ? req1_data : req0_data;
      sel_amt    = gnt1 ? req1_amt  : req0_amt;
      sel_dir    = gnt1 ? req1_dir  : req0_dir;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (sel_amt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (cnt <= AMT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Working registers: loaded on accept, then shifted once per SHIFT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work <= '0;
         cnt  <= '0;
         dir  <= 1'b0;
         id   <= 1'b0;
         rr   <= 1'b0;
      end else begin
         if (accept) begin
            work <= sel_data;
            cnt  <= sel_amt;
            dir  <= sel_dir;
            id   <= gnt1;
         end else if (state == SHIFT) begin
            work <= dir ? (work >> 1) : (work << 1);
            cnt  <= cnt - AMT_W'(1);
         end
         if ((state == DONE) && out_ready) begin
            rr <= ~id;
         end
      end
   end

   always_comb begin
      out_valid = (state == DONE);
      out_data  = out_valid ? work : '0;
      out_id    = out_valid & id;
      busy      = (state != IDLE);
   end

endmodule
